// File: rtl/sequenciador_medidas_hcsr04.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | sequenciador_medidas_hcsr04: periodic HC-SR04 measurement scheduler    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module sequenciador_medidas_hcsr04 #(
   parameter int PERIODO = 25_000_000,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ligar,
   input  logic        pronto_interface,
   input  logic [11:0] medida_interface,
   output logic        medir,
   output logic        reset_interface,
   output logic [11:0] medida,
   output logic        nova_medida,
   output logic        falha,
   output logic [3:0]  contagem_falhas,
   output logic [3:0]  db_estado
);

   localparam int            PW      = $clog2(PERIODO);
   localparam int            TW      = $clog2(TIMEOUT);
   localparam logic [PW-1:0] PER_MAX = PW'(PERIODO - 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ARM = TW'(2);

   typedef enum logic [3:0] {
      INICIAL  = 4'h0,
      DISPARA  = 4'h1,
      AGUARDA  = 4'h2,
      REGISTRA = 4'h3,
      ESPERA   = 4'h4,
      FALHA    = 4'hE
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [PW-1:0] per_q, per_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [11:0]   medida_q, medida_d;
   logic          falha_q, falha_d;
   logic [3:0]    falhas_q, falhas_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= INICIAL;
         per_q    <= '0;
         tmo_q    <= '0;
         medida_q <= 12'h000;
         falha_q  <= 1'b0;
         falhas_q <= 4'h0;
      end else begin
         estado_q <= estado_d;
         per_q    <= per_d;
         tmo_q    <= tmo_d;
         medida_q <= medida_d;
         falha_q  <= falha_d;
         falhas_q <= falhas_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:  if (ligar) estado_d = DISPARA;
         DISPARA:  estado_d = AGUARDA;
         // The first two AGUARDA cycles still see the previous measurement's pronto level
         AGUARDA: begin
            if (tmo_q >= TMO_ARM) begin
               if (pronto_interface)      estado_d = REGISTRA;
               else if (tmo_q == TMO_MAX) estado_d = FALHA;
            end
         end
         REGISTRA: estado_d = ESPERA;
         FALHA:    estado_d = ESPERA;
         ESPERA: begin
            if (!ligar)                estado_d = INICIAL;
            else if (per_q == PER_MAX) estado_d = DISPARA;
         end
         default:  estado_d = INICIAL;
      endcase
   end

   always_comb begin
      tmo_d    = tmo_q;
      medida_d = medida_q;
      falha_d  = falha_q;
      falhas_d = falhas_q;
      per_d    = (per_q == PER_MAX) ? per_q : per_q + PW'(1);
      // Clearing on entry makes the counter read 0 during DISPARA, giving an exact PERIODO spacing
      if (estado_d == DISPARA) per_d = '0;
      case (estado_q)
         DISPARA:  tmo_d = '0;
         AGUARDA:  if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
         REGISTRA: begin
            medida_d = medida_interface;
            falha_d  = 1'b0;
         end
         FALHA: begin
            falha_d = 1'b1;
            if (falhas_q != 4'hF) falhas_d = falhas_q + 4'd1;
         end
         default: ;
      endcase
   end

   assign medir           = (estado_q == DISPARA);
   assign reset_interface = (estado_q == FALHA);
   assign nova_medida     = (estado_q == REGISTRA);
   assign medida          = medida_q;
   assign falha           = falha_q;
   assign contagem_falhas = falhas_q;
   assign db_estado       = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_medidas_hcsr04.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sequenciador_medidas_hcsr04: directed bench with interface model    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_sequenciador_medidas_hcsr04;

   localparam int PERIODO = 100;
   localparam int TIMEOUT = 40;
   localparam int M_RESP  = 0;
   localparam int M_NUNCA = 1;
   localparam int M_FIXO  = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        ligar;
   logic        pronto_interface;
   logic [11:0] medida_interface;
   logic        medir;
   logic        reset_interface;
   logic [11:0] medida;
   logic        nova_medida;
   logic        falha;
   logic [3:0]  contagem_falhas;
   logic [3:0]  db_estado;

   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          modo       = M_RESP;
   int          atraso     = 20;
   int          due        = -1;
   int          last_medir = -1000;
   int          n_medir    = 0;
   int          n_nova     = 0;
   int          n_rst_if   = 0;
   logic [11:0] valor      = 12'h123;
   logic [11:0] exp_medida = 12'h000;
   bit          pend       = 1'b0;
   logic [11:0] sb_q[$];

   always #5 clock = ~clock;

   sequenciador_medidas_hcsr04 #(
      .PERIODO (PERIODO),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .ligar            (ligar),
      .pronto_interface (pronto_interface),
      .medida_interface (medida_interface),
      .medir            (medir),
      .reset_interface  (reset_interface),
      .medida           (medida),
      .nova_medida      (nova_medida),
      .falha            (falha),
      .contagem_falhas  (contagem_falhas),
      .db_estado        (db_estado)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_medir"},  32'(medir), 32'd0);
      check({tag, "_rstif"},  32'(reset_interface), 32'd0);
      check({tag, "_medida"}, 32'(medida), 32'd0);
      check({tag, "_nova"},   32'(nova_medida), 32'd0);
      check({tag, "_falha"},  32'(falha), 32'd0);
      check({tag, "_cont"},   32'(contagem_falhas), 32'd0);
      check({tag, "_estado"}, 32'(db_estado), 32'd0);
   endtask

   // One clock: sample after the edge, run the interface model and the scoreboard
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (pend) begin
         check("medida_latched", 32'(medida), 32'(exp_medida));
         pend = 1'b0;
      end
      if (nova_medida) begin
         n_nova++;
         check("nova_has_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            exp_medida = sb_q.pop_front();
            pend       = 1'b1;
         end
      end
      if (reset_interface) begin
         n_rst_if++;
         check("rst_if_delay", 32'(cyc - last_medir), 32'(TIMEOUT + 1));
         check("falha_state_code", 32'(db_estado), 32'hE);
      end
      if (medir) begin
         n_medir++;
         last_medir = cyc;
         if (modo == M_RESP) begin
            pronto_interface = 1'b0;
            due              = cyc + atraso;
         end else if (modo == M_FIXO) begin
            sb_q.push_back(valor);
         end
      end else if (modo == M_RESP && cyc == due) begin
         pronto_interface = 1'b1;
         medida_interface = valor;
         sb_q.push_back(valor);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wait_medir(output int c);
      bit seen = 1'b0;
      c = -1;
      for (int k = 0; k < 300 && !seen; k++) begin
         tick();
         seen = medir;
      end
      if (seen) c = cyc;
      else check("medir_wait", 32'(medir), 32'd1);
   endtask

   task automatic wait_rst_if();
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         seen = reset_interface;
      end
      if (!seen) check("rst_if_wait", 32'(reset_interface), 32'd1);
   endtask

   initial begin
      int c;
      int prev;
      int m0;
      int r0;

      reset            = 1'b0;
      ligar            = 1'b0;
      pronto_interface = 1'b0;
      medida_interface = 12'h000;
      ticks(3);
      check_reset_outputs("reset");
      reset = 1'b1;
      cyc   = 0;

      // Normal periodic measurements
      ticks(5);
      ligar = 1'b1;
      wait_medir(c);
      check("medir_first_cycle", 32'(c), 32'd6);
      prev = c;
      for (int i = 0; i < 2; i++) begin
         wait_medir(c);
         check("medir_period", 32'(c - prev), 32'(PERIODO));
         prev = c;
      end
      ticks(30);
      check("nova_count", 32'(n_nova), 32'd3);
      check("medida_123", 32'(medida), 32'h123);
      check("falha_clear", 32'(falha), 32'd0);
      check("no_rst_if", 32'(n_rst_if), 32'd0);

      // Missing echo: timeouts and saturation
      modo             = M_NUNCA;
      pronto_interface = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         wait_medir(c);
         check("medir_period_to", 32'(c - prev), 32'(PERIODO));
         prev = c;
         wait_rst_if();
         tick();
         check("falha_set", 32'(falha), 32'd1);
         check("cont_falhas", 32'(contagem_falhas), 32'((i > 15) ? 15 : i));
      end

      modo  = M_RESP;
      valor = 12'h045;
      wait_medir(c);
      check("medir_period_rec", 32'(c - prev), 32'(PERIODO));
      ticks(30);
      check("falha_recovered", 32'(falha), 32'd0);
      check("medida_045", 32'(medida), 32'h045);
      check("cont_sat_kept", 32'(contagem_falhas), 32'hF);

      // Stale pronto held high
      modo             = M_FIXO;
      valor            = 12'h387;
      medida_interface = valor;
      pronto_interface = 1'b1;
      wait_medir(c);
      ticks(3);
      check("stale_still_aguarda", 32'(db_estado), 32'h2);
      check("stale_no_nova", 32'(nova_medida), 32'd0);
      tick();
      check("stale_registra", 32'(db_estado), 32'h3);
      check("stale_nova", 32'(nova_medida), 32'd1);
      ticks(2);

      // pronto on the last timeout cycle
      modo   = M_RESP;
      atraso = TIMEOUT;
      valor  = 12'h250;
      r0     = n_rst_if;
      wait_medir(c);
      ticks(TIMEOUT + 1);
      check("edge_registra", 32'(db_estado), 32'h3);
      check("edge_nova", 32'(nova_medida), 32'd1);
      tick();
      check("edge_falha", 32'(falha), 32'd0);
      check("edge_no_rst_if", 32'(n_rst_if), 32'(r0));
      check("edge_espera", 32'(db_estado), 32'h4);

      // ligar dropped mid-measurement
      atraso = 20;
      valor  = 12'h099;
      wait_medir(c);
      ticks(5);
      ligar = 1'b0;
      ticks(16);
      check("drop_nova", 32'(nova_medida), 32'd1);
      tick();
      check("drop_espera", 32'(db_estado), 32'h4);
      tick();
      check("drop_inicial", 32'(db_estado), 32'h0);
      m0 = n_medir;
      ticks(150);
      check("drop_no_medir", 32'(n_medir), 32'(m0));
      check("drop_medida_held", 32'(medida), 32'h099);

      // Asynchronous reset mid-AGUARDA
      ligar = 1'b1;
      wait_medir(c);
      ticks(5);
      check("pre_reset_aguarda", 32'(db_estado), 32'h2);
      ligar = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      sb_q.delete();
      pend = 1'b0;
      due  = -1;
      ticks(3);
      reset = 1'b1;
      tick();
      check("post_reset_estado", 32'(db_estado), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
